// File: rtl/restore_stream_loader.sv
// AXI-Stream (addr,data) pair loader driving the CPU restore write port; one held write per pair.
// s_tready is registered and only high while fetching a pair, so every other state backpressures.
`timescale 1ns/1ps
module restore_stream_loader #(
  parameter int SETTLE_PRE  = 10,
  parameter int WE_HOLD     = 4,
  parameter int WE_GAP      = 1,
  parameter int SETTLE_POST = 100
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] s_tdata,
  input  logic [3:0]  s_tkeep,
  input  logic        s_tlast,
  input  logic        s_tvalid,
  output logic        s_tready,
  output logic        restore_mode_out,
  output logic [31:0] cpu_write_addr_out,
  output logic [31:0] cpu_write_data_out,
  output logic        cpu_write_enable_out,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] write_count
);

  typedef enum logic [2:0] {IDLE, PRE, GET_ADDR, GET_DATA, WRITE, GAP, POST} state_t;

  localparam logic [15:0] PRE_LD  = 16'(SETTLE_PRE - 1);
  localparam logic [15:0] HOLD_LD = 16'(WE_HOLD - 1);
  localparam logic [15:0] GAP_LD  = 16'(WE_GAP - 1);
  localparam logic [15:0] POST_LD = 16'(SETTLE_POST - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic [31:0] hold_addr_q, hold_addr_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        bad_q, bad_d;
  logic        last_q, last_d;
  logic        abort_pend_q, abort_pend_d;
  logic        rdy_q, rdy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        hs;

  assign hs = s_tvalid & rdy_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wcnt_d       = wcnt_q;
    hold_addr_d  = hold_addr_q;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    bad_d        = bad_q;
    last_d       = last_q;
    abort_pend_d = abort_pend_q;
    done_d       = 1'b0;
    err_d        = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = PRE;
          cnt_d        = PRE_LD;
          err_d        = 1'b0;
          wcnt_d       = 16'd0;
          abort_pend_d = 1'b0;
        end
      end
      PRE: begin
        if (abort) begin
          state_d = POST;
          cnt_d   = POST_LD;
        end else if (cnt_q == 16'd0) begin
          state_d = GET_ADDR;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      GET_ADDR: begin
        // abort wins over a same-cycle handshake: the word is consumed and dropped
        if (abort) begin
          state_d = POST;
          cnt_d   = POST_LD;
        end else if (hs) begin
          if (s_tlast) begin
            err_d   = 1'b1;
            state_d = POST;
            cnt_d   = POST_LD;
          end else begin
            hold_addr_d = s_tdata;
            bad_d       = (s_tkeep != 4'hF);
            state_d     = GET_DATA;
          end
        end
      end
      GET_DATA: begin
        if (abort) begin
          state_d = POST;
          cnt_d   = POST_LD;
        end else if (hs) begin
          last_d = s_tlast;
          if (bad_q || (s_tkeep != 4'hF)) begin
            err_d   = 1'b1;
            state_d = GAP;
            cnt_d   = GAP_LD;
          end else begin
            waddr_d = hold_addr_q;
            wdata_d = s_tdata;
            wcnt_d  = (wcnt_q == 16'hFFFF) ? wcnt_q : wcnt_q + 16'd1;
            state_d = WRITE;
            cnt_d   = HOLD_LD;
          end
        end
      end
      WRITE: begin
        if (abort) abort_pend_d = 1'b1;
        if (cnt_q == 16'd0) begin
          if (abort_pend_q || abort) begin
            state_d = POST;
            cnt_d   = POST_LD;
          end else begin
            state_d = GAP;
            cnt_d   = GAP_LD;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      GAP: begin
        if (abort || (cnt_q == 16'd0 && last_q)) begin
          state_d = POST;
          cnt_d   = POST_LD;
        end else if (cnt_q == 16'd0) begin
          state_d = GET_ADDR;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      POST: begin
        if (cnt_q == 16'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    rdy_d = (state_d == GET_ADDR) || (state_d == GET_DATA);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q      <= IDLE;
      cnt_q        <= 16'd0;
      wcnt_q       <= 16'd0;
      hold_addr_q  <= 32'd0;
      waddr_q      <= 32'd0;
      wdata_q      <= 32'd0;
      bad_q        <= 1'b0;
      last_q       <= 1'b0;
      abort_pend_q <= 1'b0;
      rdy_q        <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wcnt_q       <= wcnt_d;
      hold_addr_q  <= hold_addr_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      bad_q        <= bad_d;
      last_q       <= last_d;
      abort_pend_q <= abort_pend_d;
      rdy_q        <= rdy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign s_tready             = rdy_q;
  assign restore_mode_out     = (state_q != IDLE);
  assign busy                 = (state_q != IDLE);
  assign cpu_write_enable_out = (state_q == WRITE);
  assign cpu_write_addr_out   = waddr_q;
  assign cpu_write_data_out   = wdata_q;
  assign done                 = done_q;
  assign err                  = err_q;
  assign write_count          = wcnt_q;

endmodule

// File: tb/tb_restore_stream_loader.sv
// Directed bench for restore_stream_loader: packet sequencing, error handling, abort and async reset.
`timescale 1ns/1ps
module tb_restore_stream_loader;

  logic        clk = 1'b0;
  logic        nreset, start, abort;
  logic [31:0] s_tdata;
  logic [3:0]  s_tkeep;
  logic        s_tlast, s_tvalid, s_tready;
  logic        restore_mode_out, cpu_write_enable_out, busy, done, err;
  logic [31:0] cpu_write_addr_out, cpu_write_data_out;
  logic [15:0] write_count;

  restore_stream_loader dut (
    .clk(clk), .nreset(nreset), .start(start), .abort(abort),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tvalid(s_tvalid),
    .s_tready(s_tready), .restore_mode_out(restore_mode_out),
    .cpu_write_addr_out(cpu_write_addr_out), .cpu_write_data_out(cpu_write_data_out),
    .cpu_write_enable_out(cpu_write_enable_out), .busy(busy), .done(done), .err(err),
    .write_count(write_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // packet under test
  logic [31:0] p_dat[8];
  logic [3:0]  p_keep[8];
  logic        p_last[8];
  int          p_n;

  // observation state, updated on the falling edge
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          hold_q[$];
  int          hold_len, stable_bad, done_cnt, done_gap, since_en, hs_cnt, pre_cnt;
  bit          seen_rdy, en_prev;

  always @(negedge clk) begin
    if (cpu_write_enable_out) begin
      if (!en_prev) begin
        wr_addr.push_back(cpu_write_addr_out);
        wr_data.push_back(cpu_write_data_out);
        hold_len = 0;
      end else if (cpu_write_addr_out !== wr_addr[$] || cpu_write_data_out !== wr_data[$]) begin
        stable_bad++;
      end
      hold_len++;
      since_en = 0;
    end else begin
      if (en_prev) hold_q.push_back(hold_len);
      if (done) done_gap = since_en;
      since_en++;
    end
    en_prev = cpu_write_enable_out;
    if (done) done_cnt++;
    if (s_tvalid && s_tready) hs_cnt++;
    if (s_tready) seen_rdy = 1;
    if (restore_mode_out && !seen_rdy) pre_cnt++;
  end

  task automatic clr_mon();
    wr_addr.delete(); wr_data.delete(); hold_q.delete();
    hold_len = 0; stable_bad = 0; done_cnt = 0; done_gap = -1; since_en = 0;
    hs_cnt = 0; pre_cnt = 0; seen_rdy = 0; en_prev = 0;
  endtask

  task automatic set_word(input int idx, input logic [31:0] d, input logic [3:0] k, input logic l);
    p_dat[idx] = d; p_keep[idx] = k; p_last[idx] = l;
  endtask

  task automatic pkt_two_pairs();
    set_word(0, 32'h100, 4'hF, 1'b0);
    set_word(1, 32'hDEADBEEF, 4'hF, 1'b0);
    set_word(2, 32'h104, 4'hF, 1'b0);
    set_word(3, 32'h12345678, 4'hF, 1'b1);
    p_n = 4;
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic drive_pkt(input bit toggle);
    int i;
    int cyc;
    bit hs;
    i = 0; cyc = 0;
    while (i < p_n && cyc < 800 && busy) begin
      s_tvalid = toggle ? (cyc % 2 == 0) : 1'b1;
      s_tdata  = p_dat[i];
      s_tkeep  = p_keep[i];
      s_tlast  = p_last[i];
      @(negedge clk);
      hs = s_tvalid && s_tready;
      @(posedge clk); #1;
      if (hs) i++;
      cyc++;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    chk("drv_timeout", 32'(cyc >= 800), 32'd0);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
    @(negedge clk); #1;
  endtask

  task automatic chk_pair(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
    if (wr_addr.size() > idx) begin
      chk({tag, "_addr"}, wr_addr[idx], a);
      chk({tag, "_data"}, wr_data[idx], d);
      chk({tag, "_hold"}, 32'(hold_q[idx]), 32'd4);
    end
  endtask

  initial begin
    nreset = 1'b0; start = 1'b0; abort = 1'b0;
    s_tdata = '0; s_tkeep = 4'hF; s_tlast = 1'b0; s_tvalid = 1'b0;
    clr_mon();
    #12;
    chk("rst_mode",  32'(restore_mode_out), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_rdy",   32'(s_tready), 32'd0);
    chk("rst_we",    32'(cpu_write_enable_out), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_err",   32'(err), 32'd0);
    chk("rst_wcnt",  32'(write_count), 32'd0);
    chk("rst_addr",  cpu_write_addr_out, 32'd0);
    @(posedge clk); #1 nreset = 1'b1;

    // two pairs, tvalid always high
    pkt_two_pairs();
    clr_mon();
    do_start();
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_mode", 32'(restore_mode_out), 32'd1);
    drive_pkt(1'b0);
    wait_idle();
    chk("t1_pre",    32'(pre_cnt), 32'd10);
    chk("t1_nwr",    32'(wr_addr.size()), 32'd2);
    chk_pair("t1_p0", 0, 32'h100, 32'hDEADBEEF);
    chk_pair("t1_p1", 1, 32'h104, 32'h12345678);
    chk("t1_stable", 32'(stable_bad), 32'd0);
    chk("t1_wcnt",   32'(write_count), 32'd2);
    chk("t1_done",   32'(done_cnt), 32'd1);
    chk("t1_dgap",   32'(done_gap), 32'd101);
    chk("t1_err",    32'(err), 32'd0);
    chk("t1_hs",     32'(hs_cnt), 32'd4);
    chk("t1_mode0",  32'(restore_mode_out), 32'd0);

    // same packet, tvalid toggling
    clr_mon();
    do_start();
    drive_pkt(1'b1);
    wait_idle();
    chk("t2_nwr",  32'(wr_addr.size()), 32'd2);
    chk_pair("t2_p0", 0, 32'h100, 32'hDEADBEEF);
    chk_pair("t2_p1", 1, 32'h104, 32'h12345678);
    chk("t2_hs",   32'(hs_cnt), 32'd4);
    chk("t2_wcnt", 32'(write_count), 32'd2);

    // tlast on an address word
    set_word(0, 32'h200, 4'hF, 1'b0);
    set_word(1, 32'hAAAA5555, 4'hF, 1'b0);
    set_word(2, 32'h204, 4'hF, 1'b1);
    p_n = 3;
    clr_mon();
    do_start();
    drive_pkt(1'b0);
    wait_idle();
    chk("t3_nwr",  32'(wr_addr.size()), 32'd1);
    chk_pair("t3_p0", 0, 32'h200, 32'hAAAA5555);
    chk("t3_err",  32'(err), 32'd1);
    chk("t3_wcnt", 32'(write_count), 32'd1);
    chk("t3_done", 32'(done_cnt), 32'd1);

    // partial keep on the first data word
    set_word(0, 32'h300, 4'hF, 1'b0);
    set_word(1, 32'h11111111, 4'h7, 1'b0);
    set_word(2, 32'h304, 4'hF, 1'b0);
    set_word(3, 32'h22222222, 4'hF, 1'b1);
    p_n = 4;
    clr_mon();
    do_start();
    drive_pkt(1'b0);
    wait_idle();
    chk("t4_nwr",  32'(wr_addr.size()), 32'd1);
    chk_pair("t4_p1", 0, 32'h304, 32'h22222222);
    chk("t4_wcnt", 32'(write_count), 32'd1);
    chk("t4_err",  32'(err), 32'd1);
    chk("t4_hs",   32'(hs_cnt), 32'd4);

    // abort during the second cycle of the first hold; start also clears err
    set_word(0, 32'h400, 4'hF, 1'b0);
    set_word(1, 32'h55, 4'hF, 1'b0);
    set_word(2, 32'h404, 4'hF, 1'b0);
    set_word(3, 32'h66, 4'hF, 1'b1);
    p_n = 4;
    clr_mon();
    do_start();
    chk("t5_errclr", 32'(err), 32'd0);
    fork
      drive_pkt(1'b0);
      begin
        for (int k = 0; k < 500 && !cpu_write_enable_out; k++) @(negedge clk);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
      end
    join
    wait_idle();
    chk("t5_nwr",  32'(wr_addr.size()), 32'd1);
    chk_pair("t5_p0", 0, 32'h400, 32'h55);
    chk("t5_hs",   32'(hs_cnt), 32'd2);
    chk("t5_dgap", 32'(done_gap), 32'd100);
    chk("t5_done", 32'(done_cnt), 32'd1);
    chk("t5_wcnt", 32'(write_count), 32'd1);

    // async reset in the middle of a write hold
    pkt_two_pairs();
    clr_mon();
    do_start();
    fork
      drive_pkt(1'b0);
      begin
        for (int k = 0; k < 500 && !cpu_write_enable_out; k++) @(negedge clk);
        #2 nreset = 1'b0;
        #1;
        chk("t6_mode", 32'(restore_mode_out), 32'd0);
        chk("t6_we",   32'(cpu_write_enable_out), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1 nreset = 1'b1;
      end
    join
    chk("t6_wcnt0", 32'(write_count), 32'd0);
    clr_mon();
    do_start();
    chk("t6_wcnt_start", 32'(write_count), 32'd0);
    drive_pkt(1'b0);
    wait_idle();
    chk("t6_nwr",  32'(wr_addr.size()), 32'd2);
    chk_pair("t6_p0", 0, 32'h100, 32'hDEADBEEF);
    chk_pair("t6_p1", 1, 32'h104, 32'h12345678);
    chk("t6_wcnt", 32'(write_count), 32'd2);
    chk("t6_done", 32'(done_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
